// File: rtl/fpro_timer_core.sv
// -----------------------------------------------------------------------------
// fpro_timer_core
//
// FPro MMIO slot peripheral: W-bit free-running / periodic timer with a
// programmable period, sticky match and overflow flags and a level interrupt.
// Intended for slot 0 (system timer).
//
// Ports:
//   clk      in   1   system clock
//   rst      in   1   synchronous active-high reset
//   cs       in   1   slot select from the MMIO controller
//   write    in   1   write strobe (qualified by cs)
//   read     in   1   read strobe (qualified by cs)
//   addr     in   5   register word index
//   wr_data  in  32   write data
//   rd_data  out 32   read data, combinational from addr and registered state
//   irq      out  1   registered level interrupt = match_flag & irq_en
//
// Register map (word index):
//   0 COUNT_LO  R    count[31:0]; a read strobe also snapshots count[W-1:32]
//   1 COUNT_HI  R    snapshot (or live) count[W-1:32], zero-extended
//   2 CTRL      R/W  bit0 go, bit1 clear (write-1 pulse, reads 0),
//                    bit2 auto_reload, bit3 irq_en
//   3 PERIOD_LO R/W  period[31:0]
//   4 PERIOD_HI R/W  period[W-1:32], zero-extended
//   5 STATUS         bit0 match_flag (W1C), bit1 ovf_flag (W1C), bit2 running
//   6..31            read 0, writes ignored
//
// Build option:
//   FPRO_TIMER_SNAPSHOT_EN  defined   -> COUNT_HI returns the shadow captured
//                                        by the last COUNT_LO read strobe
//                           undefined -> no shadow register; COUNT_HI is live
// -----------------------------------------------------------------------------
module fpro_timer_core #(
    parameter int W = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        write,
    input  logic        read,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        irq
);

    localparam int HW = W - 32;

    localparam logic [4:0] ADDR_COUNT_LO  = 5'd0;
    localparam logic [4:0] ADDR_COUNT_HI  = 5'd1;
    localparam logic [4:0] ADDR_CTRL      = 5'd2;
    localparam logic [4:0] ADDR_PERIOD_LO = 5'd3;
    localparam logic [4:0] ADDR_PERIOD_HI = 5'd4;
    localparam logic [4:0] ADDR_STATUS    = 5'd5;

    localparam logic [W-1:0] COUNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] COUNT_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] COUNT_MAX  = {W{1'b1}};

    // Architectural state
    logic [W-1:0] count_r;
    logic [W-1:0] period_r;
    logic         go_r;
    logic         auto_reload_r;
    logic         irq_en_r;
    logic         match_flag_r;
    logic         ovf_flag_r;
    logic         irq_r;

    // Decoded bus accesses and timer events
    logic         wr_en_s;
    logic         ctrl_wr_s;
    logic         period_lo_wr_s;
    logic         period_hi_wr_s;
    logic         status_wr_s;
    logic         clear_s;
    logic         match_s;
    logic         reload_s;
    logic         ovf_s;
    logic [HW-1:0] count_hi_s;
    logic [31:0]  count_hi_ext_s;
    logic [31:0]  period_hi_ext_s;

    // Next count kept as its own net so the counter register has a single,
    // easily observed input.
    wire  [W-1:0] count_nxt_s;

    assign wr_en_s        = cs & write;
    assign ctrl_wr_s      = wr_en_s & (addr == ADDR_CTRL);
    assign period_lo_wr_s = wr_en_s & (addr == ADDR_PERIOD_LO);
    assign period_hi_wr_s = wr_en_s & (addr == ADDR_PERIOD_HI);
    assign status_wr_s    = wr_en_s & (addr == ADDR_STATUS);
    assign clear_s        = ctrl_wr_s & wr_data[1];

    // A zero period disables matching, leaving the timer free-running.
    assign match_s  = go_r & (period_r != COUNT_ZERO) & (count_r == period_r);
    assign reload_s = match_s & auto_reload_r;
    // A wrap only counts as overflow when the reload did not take the counter to 0 first.
    assign ovf_s    = go_r & (count_r == COUNT_MAX) & ~reload_s;

    // Priority: clear write, auto-reload, increment, hold.
    assign count_nxt_s = clear_s  ? COUNT_ZERO :
                         reload_s ? COUNT_ZERO :
                         go_r     ? (count_r + COUNT_ONE) :
                                    count_r;

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= COUNT_ZERO;
        end else begin
            count_r <= count_nxt_s;
        end
    end

    // CTRL bits and PERIOD register; clear is a pulse and is not stored
    always_ff @(posedge clk) begin
        if (rst) begin
            go_r          <= 1'b0;
            auto_reload_r <= 1'b0;
            irq_en_r      <= 1'b0;
            period_r      <= COUNT_ZERO;
        end else begin
            if (ctrl_wr_s) begin
                go_r          <= wr_data[0];
                auto_reload_r <= wr_data[2];
                irq_en_r      <= wr_data[3];
            end
            if (period_lo_wr_s) begin
                period_r[31:0] <= wr_data;
            end
            if (period_hi_wr_s) begin
                period_r[W-1:32] <= wr_data[HW-1:0];
            end
        end
    end

    // Sticky flags; a set event beats a same-cycle W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            match_flag_r <= 1'b0;
            ovf_flag_r   <= 1'b0;
        end else begin
            if (match_s) begin
                match_flag_r <= 1'b1;
            end else if (status_wr_s && wr_data[0]) begin
                match_flag_r <= 1'b0;
            end
            if (ovf_s) begin
                ovf_flag_r <= 1'b1;
            end else if (status_wr_s && wr_data[1]) begin
                ovf_flag_r <= 1'b0;
            end
        end
    end

    // Level interrupt, one cycle behind the flag / enable
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= match_flag_r & irq_en_r;
        end
    end

    assign irq = irq_r;

`ifdef FPRO_TIMER_SNAPSHOT_EN
    logic          rd_en_s;
    logic [HW-1:0] shadow_hi_r;

    assign rd_en_s = cs & read;

    // Capture the upper count bits in the same cycle as a COUNT_LO read so a
    // LO-then-HI pair is coherent across a carry out of bit 31.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_hi_r <= {HW{1'b0}};
        end else if (rd_en_s && (addr == ADDR_COUNT_LO)) begin
            shadow_hi_r <= count_r[W-1:32];
        end
    end

    assign count_hi_s = shadow_hi_r;
`else
    // Without the shadow the read strobe has no side effect.
    logic unused_read_s;

    assign unused_read_s = read;
    assign count_hi_s    = count_r[W-1:32];
`endif

    // Zero-extend the HI fields to the 32-bit bus
    always_comb begin
        count_hi_ext_s              = 32'd0;
        period_hi_ext_s             = 32'd0;
        count_hi_ext_s[HW-1:0]      = count_hi_s;
        period_hi_ext_s[HW-1:0]     = period_r[W-1:32];
    end

    // Zero-latency read mux
    always_comb begin
        rd_data = 32'd0;
        case (addr)
            ADDR_COUNT_LO:  rd_data = count_r[31:0];
            ADDR_COUNT_HI:  rd_data = count_hi_ext_s;
            ADDR_CTRL:      rd_data = {28'd0, irq_en_r, auto_reload_r, 1'b0, go_r};
            ADDR_PERIOD_LO: rd_data = period_r[31:0];
            ADDR_PERIOD_HI: rd_data = period_hi_ext_s;
            ADDR_STATUS:    rd_data = {29'd0, go_r, ovf_flag_r, match_flag_r};
            default:        rd_data = 32'd0;
        endcase
    end

endmodule

// File: doc/fpro_timer_core.md
# fpro_timer_core

Slot peripheral on the FPro MMIO bus: a W-bit free-running/periodic timer with programmable period, sticky match and overflow flags, and a level interrupt. It sits directly downstream of the MMIO slot controller. It consumes one slot's `cs`/`write`/`read`/`addr`/`wr_data` signals and returns `rd_data` to that slot's read-data input. It is intended for slot 0 (system timer).

## Interface
Parameters:
- `W`, default 48: counter and period width; legal range 33..64. The HI registers carry bits [W-1:32], zero-extended to 32 bits.

Ports:
- `clk` input 1: system clock; the only clock.
- `rst` input 1: reset; synchronous, active-high.
- `cs` input 1: slot select from the MMIO controller.
- `write` input 1: write strobe; effective only when `cs` is high.
- `read` input 1: read strobe; effective only when `cs` is high.
- `addr` input 5: register index 0..31.
- `wr_data` input 32: write data.
- `rd_data` output 32: read data. Combinational from `addr` and registered state.
- `irq` output 1: registered level interrupt, equal to `match_flag & irq_en`.

## Operation
Register map (word index):
- 0 COUNT_LO (R): `count[31:0]`. A read strobe here also loads `shadow_hi <= count[W-1:32]`.
- 1 COUNT_HI (R): returns `shadow_hi`.
- 2 CTRL (R/W):
  - bit0 `go`.
  - bit1 `clear`: write-1 pulse, always reads 0.
  - bit2 `auto_reload`.
  - bit3 `irq_en`.
  - Other bits read 0.
- 3 PERIOD_LO (R/W): `period[31:0]`.
- 4 PERIOD_HI (R/W): `period[W-1:32]`; upper bits are ignored on write and read 0.
- 5 STATUS:
  - bit0 `match_flag`: W1C.
  - bit1 `ovf_flag`: W1C.
  - bit2 `running`: RO, mirrors `go`.
- 6..31: read 0; writes ignored.

Counter update, in priority order each cycle:
1. `rst`: `count <= 0`.
2. Write to CTRL with bit1 set: `count <= 0`. This applies regardless of `go` and happens in the same edge as the CTRL update.
3. `go` and `auto_reload` and `period != 0` and `count == period`: `count <= 0`.
4. `go`: `count <= count + 1`, modulo 2^W.
5. Otherwise: hold.

Flags:
- Match event: `go & (period != 0) & (count == period)`. It sets `match_flag`.
- With `period == 0`, match detection is disabled and the timer is free-running.
- Overflow event: `go & count == 2^W-1`, and no reload is taken. It sets `ovf_flag`.
- If a set event and a W1C write to the same flag occur in the same cycle, the set wins.
- Without `auto_reload`, a match sets the flag once per pass; the counter keeps counting.

Writes to PERIOD while running take effect for the comparison on the next cycle.

## Timing
- Reset values: `count`, `shadow_hi`, `period`, CTRL bits, flags and `irq` are all 0. After reset, `rd_data` is 0 for every address.
- Register writes are captured on the rising edge with `cs & write` and are visible on `rd_data` in the following cycle.
- Reads have zero latency: `rd_data` is valid in the same cycle as `addr`. This matches the combinational read mux in the slot controller.
- Counter: the first increment is on the edge after the edge that captures `go = 1`.
- Auto-reload sequence with period P: count runs 0, 1, …, P, 0, … The period is P+1 cycles. `match_flag` rises on the edge leaving count P.
- `irq` rises one cycle after `match_flag` is set while `irq_en = 1`. It falls one cycle after the flag is cleared or `irq_en` is cleared.
- Snapshot: a COUNT_LO read and its `shadow_hi` capture happen in the same cycle. This makes a LO-then-HI read pair coherent even across a carry from bit 31.
- `rst` asserted mid-count: all state returns to reset values on that edge; no flag survives.

## Configuration
- `FPRO_TIMER_SNAPSHOT_EN` defined: COUNT_HI returns `shadow_hi`, which is latched on COUNT_LO reads as described above.
- `FPRO_TIMER_SNAPSHOT_EN` undefined: the shadow register is not built. COUNT_HI returns live `count[W-1:32]`, and COUNT_LO reads have no side effect.

## Test plan
- Reset and idle: assert `rst`, release, read addresses 0..7. All return 0, `irq` = 0, and the count stays 0 for 100 cycles.
- Free run and clear: write CTRL = 0x1, wait 10 cycles, read COUNT_LO. The value is 10 ± 1 within a fixed, checked offset. Then write CTRL = 0x3; COUNT_LO reads 0 or 1 next cycle and `go` stays 1.
- Periodic with irq: PERIOD_LO = 4, CTRL = 0xD. Count sequence is 0..4,0..4. `match_flag` sets every 5 cycles and `irq` goes high one cycle after. Write STATUS = 0x1: `irq` drops, then re-asserts on the next match.
- W1C collision: time a STATUS = 0x1 write to coincide with a match edge. `match_flag` remains 1.
- Overflow and snapshot: use a debug-forced count of 0x0000_FFFF_FFFF (W = 48) with `go`. After 1 cycle, `ovf_flag` is 0. Read COUNT_LO at 0xFFFF_FFFF; the following COUNT_HI read returns 0x0000 with the snapshot enabled and 0x0001 without it. Force 2^48-1: after 1 cycle `count` = 0 and `ovf_flag` = 1.
- Unmapped and gated access: writes at addresses 6..31, and writes with `cs = 0` to CTRL, change no state. Reads at 6..31 return 0.
